// File: rtl/rf_line_sequencer_pkg.sv
// Shared constants, state encoding and beat payload for the RF line sequencer.
// The RF sample store is 24100 entries of 16 bits; addresses wrap after the last entry.
package rf_pkg;

    localparam int RF_DEPTH  = 24100;
    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 15;

    localparam logic [RF_ADDR_W-1:0] RF_LAST_ADDR = RF_ADDR_W'(RF_DEPTH - 1);
    localparam logic [RF_ADDR_W-1:0] RF_DEPTH_A   = RF_ADDR_W'(RF_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_GAP    = 2'd3
    } rf_state_t;

    typedef struct packed {
        logic [RF_DATA_W-1:0] data;
        logic                 last;
        logic [7:0]           line;
    } rf_beat_t;

    // Sequential read address with wrap from the last entry back to 0.
    function automatic logic [RF_ADDR_W-1:0] rf_next_addr(input logic [RF_ADDR_W-1:0] addr);
        logic [RF_ADDR_W-1:0] nxt;
        if (addr == RF_LAST_ADDR) begin
            nxt = '0;
        end else begin
            nxt = addr + RF_ADDR_W'(1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rf_line_sequencer_if.sv
// Memory read port and sample output stream of the RF line sequencer.
// master = sequencer side, slave = memory/downstream side.
interface rf_line_sequencer_if;
    import rf_pkg::*;

    logic                 mem_en;
    logic [RF_ADDR_W-1:0] mem_addr;
    logic [RF_DATA_W-1:0] mem_rdata;
    logic                 m_valid;
    logic                 m_ready;
    logic [RF_DATA_W-1:0] m_data;
    logic                 m_last;
    logic [7:0]           m_line;

    modport master (
        output mem_en,
        output mem_addr,
        input  mem_rdata,
        output m_valid,
        input  m_ready,
        output m_data,
        output m_last,
        output m_line
    );

    modport slave (
        input  mem_en,
        input  mem_addr,
        output mem_rdata,
        input  m_valid,
        output m_ready,
        input  m_data,
        input  m_last,
        input  m_line
    );

endinterface

// File: rtl/rf_skid_fifo.sv
// Two-entry FIFO of sample beats; the head entry is held in a flop so the
// stream outputs come straight from registers. flush empties it in one cycle.
module rf_skid_fifo
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  rf_beat_t   push_beat,
    input  logic       pop,
    output rf_beat_t   head,
    output logic [1:0] count
);

    rf_beat_t   head_q, head_d;
    rf_beat_t   tail_q, tail_d;
    logic [1:0] count_q, count_d;
    logic       pop_s;
    logic       push_s;

    // Next-state of the two entries and the occupancy count.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        pop_s   = pop && (count_q != 2'd0);
        push_s  = push && ((count_q != 2'd2) || pop_s);
        if (flush) begin
            count_d = 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = push_beat;
                    end else begin
                        tail_d = push_beat;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                    end else begin
                        head_d = head_q;
                    end
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = push_beat;
                    end else begin
                        head_d = push_beat;
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    // Entry and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign head  = head_q;
    assign count = count_q;

endmodule

// File: rtl/rf_line_sequencer.sv
// Triggered, back-pressured framing of RF store playback into receive lines.
// Reads are issued only while FIFO entries plus returning read data leave room.
module rf_line_sequencer
    import rf_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    input  logic [RF_ADDR_W-1:0] cfg_base,
    input  logic [15:0]          cfg_line_len,
    input  logic [7:0]           cfg_num_lines,
    input  logic [7:0]           cfg_gap,
    rf_line_sequencer_if.master  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    rf_state_t            state_q, state_d;
    logic [RF_ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]          line_len_q, line_len_d;
    logic [15:0]          issued_q, issued_d;
    logic [7:0]           num_lines_q, num_lines_d;
    logic [7:0]           gap_q, gap_d;
    logic [7:0]           gap_cnt_q, gap_cnt_d;
    logic [7:0]           issue_line_q, issue_line_d;
    logic                 pend_q, pend_d;
    logic                 pend_last_q, pend_last_d;
    logic [7:0]           pend_line_q, pend_line_d;
    logic                 err_q, err_d;
    logic                 done_q, done_d;

    logic [1:0]           fifo_count_s;
    rf_beat_t             head_s;
    rf_beat_t             push_beat_s;
    logic                 m_valid_s;
    logic                 pop_s;
    logic [2:0]           occ_s;
    logic                 issue_s;
    logic                 last_issue_s;
    logic                 last_hs_s;
    logic                 cfg_ok_s;

    assign m_valid_s    = (fifo_count_s != 2'd0);
    assign pop_s        = m_valid_s && bus.m_ready;
    assign occ_s        = {1'b0, fifo_count_s} + {2'b00, pend_q};
    // A beat leaving this cycle frees the slot the new read will eventually need.
    assign issue_s      = !abort && (state_q == ST_STREAM) && (pop_s || (occ_s < 3'd2));
    assign last_issue_s = (issued_q == (line_len_q - 16'd1));
    assign last_hs_s    = pop_s && head_s.last;
    assign cfg_ok_s     = (cfg_line_len != 16'd0) && (cfg_num_lines != 8'd0) &&
                          (cfg_base < RF_DEPTH_A);
    assign push_beat_s  = '{data: bus.mem_rdata, last: pend_last_q, line: pend_line_q};

    rf_skid_fifo u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (abort),
        .push      (pend_q),
        .push_beat (push_beat_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (fifo_count_s)
    );

    // Frame FSM with address, sample, line and gap counters.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        line_len_d   = line_len_q;
        issued_d     = issued_q;
        num_lines_d  = num_lines_q;
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
        issue_line_d = issue_line_q;
        err_d        = err_q;
        done_d       = 1'b0;
        pend_d       = issue_s;
        pend_last_d  = last_issue_s;
        pend_line_d  = issue_line_q;
        if (abort) begin
            state_d = ST_IDLE;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (cfg_ok_s) begin
                            state_d      = ST_STREAM;
                            err_d        = 1'b0;
                            addr_d       = cfg_base;
                            line_len_d   = cfg_line_len;
                            num_lines_d  = cfg_num_lines;
                            gap_d        = cfg_gap;
                            issued_d     = 16'd0;
                            issue_line_d = 8'd0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_STREAM: begin
                    if (issue_s) begin
                        addr_d = rf_next_addr(addr_q);
                        if (last_issue_s) begin
                            issued_d     = 16'd0;
                            issue_line_d = issue_line_q + 8'd1;
                            state_d      = ST_DRAIN;
                        end else begin
                            issued_d = issued_q + 16'd1;
                        end
                    end else begin
                        state_d = ST_STREAM;
                    end
                end
                ST_DRAIN: begin
                    if (last_hs_s) begin
                        if (head_s.line == (num_lines_q - 8'd1)) begin
                            done_d  = 1'b1;
                            state_d = ST_IDLE;
                        end else if (gap_q == 8'd0) begin
                            state_d = ST_STREAM;
                        end else begin
                            gap_cnt_d = gap_q;
                            state_d   = ST_GAP;
                        end
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_q == 8'd1) begin
                        state_d = ST_STREAM;
                    end else begin
                        gap_cnt_d = gap_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control and counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            line_len_q   <= 16'd0;
            issued_q     <= 16'd0;
            num_lines_q  <= 8'd0;
            gap_q        <= 8'd0;
            gap_cnt_q    <= 8'd0;
            issue_line_q <= 8'd0;
            pend_q       <= 1'b0;
            pend_last_q  <= 1'b0;
            pend_line_q  <= 8'd0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            line_len_q   <= line_len_d;
            issued_q     <= issued_d;
            num_lines_q  <= num_lines_d;
            gap_q        <= gap_d;
            gap_cnt_q    <= gap_cnt_d;
            issue_line_q <= issue_line_d;
            pend_q       <= pend_d;
            pend_last_q  <= pend_last_d;
            pend_line_q  <= pend_line_d;
            err_q        <= err_d;
            done_q       <= done_d;
        end
    end

    assign bus.mem_en   = issue_s;
    assign bus.mem_addr = addr_q;
    assign bus.m_valid  = m_valid_s;
    assign bus.m_data   = head_s.data;
    assign bus.m_last   = head_s.last;
    assign bus.m_line   = head_s.line;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_rf_line_sequencer.sv
// Scoreboard bench for rf_line_sequencer: memory model returns data = address,
// expected beats are queued at start and matched against accepted output beats.
module tb_rf_line_sequencer;
    import rf_pkg::*;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic                 abort;
    logic [RF_ADDR_W-1:0] cfg_base;
    logic [15:0]          cfg_line_len;
    logic [7:0]           cfg_num_lines;
    logic [7:0]           cfg_gap;
    logic                 busy;
    logic                 done;
    logic                 err;

    rf_line_sequencer_if bus ();

    rf_line_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .cfg_base      (cfg_base),
        .cfg_line_len  (cfg_line_len),
        .cfg_num_lines (cfg_num_lines),
        .cfg_gap       (cfg_gap),
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency sample store holding data = address.
    always @(posedge clk) begin
        if (bus.mem_en) bus.mem_rdata <= {1'b0, bus.mem_addr};
    end

    int n_cmp = 0;
    int n_mis = 0;
    int tcyc;
    rf_beat_t exp_q[$];
    rf_beat_t obs_q[$];
    int en_cyc_q[$];
    int en_addr_q[$];
    int last_hs_q[$];
    int done_q[$];
    int first_valid, max_occ, stall_changes, busy_cnt, busy_at_done;
    int abort_cyc, post_abort_valid, post_abort_busy;

    task automatic clear_obs();
        obs_q.delete(); en_cyc_q.delete(); en_addr_q.delete();
        last_hs_q.delete(); done_q.delete();
        first_valid = -1; max_occ = 0; stall_changes = 0; busy_cnt = 0; busy_at_done = 0;
        abort_cyc = -1; post_abort_valid = -1; post_abort_busy = -1;
    endtask

    // Drives start in cycle 0 and queues the expected beats of the frame.
    task automatic do_start(input int base, input int len, input int lines, input int gap, input bit push_exp);
        rf_beat_t e;
        int a;
        clear_obs();
        @(negedge clk);
        cfg_base = RF_ADDR_W'(base); cfg_line_len = 16'(len);
        cfg_num_lines = 8'(lines); cfg_gap = 8'(gap);
        start = 1'b1; abort = 1'b0; bus.m_ready = 1'b1;
        tcyc = 0;
        if (push_exp) begin
            for (int l = 0; l < lines; l++) begin
                for (int s = 0; s < len; s++) begin
                    a = (base + l * len + s) % RF_DEPTH;
                    e.data = 16'(a); e.last = (s == len - 1); e.line = 8'(l);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // Runs n_cyc cycles, recording accepted beats and timing events (no checking here).
    task automatic watch(input int n_cyc, input bit alt_ready, input int abort_beat, input int poke_cyc);
        int n_hs = 0;
        int issued = 0;
        bit prev_stall = 1'b0;
        rf_beat_t prev, cur;
        prev = '0;
        for (int k = 0; k < n_cyc; k++) begin
            @(negedge clk);
            tcyc++;
            start = 1'b0; abort = 1'b0;
            bus.m_ready = alt_ready ? ((tcyc % 2) == 1) : 1'b1;
            if (tcyc == poke_cyc) begin
                start = 1'b1; cfg_base = 15'd500; cfg_line_len = 16'd0; cfg_num_lines = 8'd1;
            end
            if (abort_beat >= 0 && abort_cyc < 0 && bus.m_valid && n_hs == abort_beat) begin
                abort = 1'b1; bus.m_ready = 1'b0; abort_cyc = tcyc;
            end
            #1;
            if (abort_cyc >= 0 && tcyc == abort_cyc + 1) begin
                post_abort_valid = int'(bus.m_valid); post_abort_busy = int'(busy);
            end
            if (issued - n_hs > max_occ) max_occ = issued - n_hs;
            if (bus.m_valid && first_valid < 0) first_valid = tcyc;
            cur.data = bus.m_data; cur.last = bus.m_last; cur.line = bus.m_line;
            if (prev_stall && cur !== prev) stall_changes++;
            prev_stall = bus.m_valid && !bus.m_ready;
            prev = cur;
            if (busy) busy_cnt++;
            if (bus.mem_en) begin
                issued++; en_cyc_q.push_back(tcyc); en_addr_q.push_back(int'(bus.mem_addr));
            end
            if (bus.m_valid && bus.m_ready) begin
                n_hs++; obs_q.push_back(cur);
                if (bus.m_last) last_hs_q.push_back(tcyc);
            end
            if (done) begin
                done_q.push_back(tcyc);
                if (busy) busy_at_done++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; abort = 1'b0; bus.m_ready = 1'b1;
        cfg_base = '0; cfg_line_len = 16'd0; cfg_num_lines = 8'd0; cfg_gap = 8'd0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({bus.mem_en, bus.m_valid, bus.m_last, busy, done, err} !== 6'b0) begin
            n_mis++; $display("FAIL reset_flags: got en/valid/last/busy/done/err=%b, want 000000",
                {bus.mem_en, bus.m_valid, bus.m_last, busy, done, err}); end
        n_cmp++; if (bus.mem_addr !== 15'd0) begin n_mis++; $display("FAIL reset_addr: got %0d, want 0", bus.mem_addr); end
        n_cmp++; if (bus.m_data !== 16'd0) begin n_mis++; $display("FAIL reset_data: got %0d, want 0", bus.m_data); end
        n_cmp++; if (bus.m_line !== 8'd0) begin n_mis++; $display("FAIL reset_line: got %0d, want 0", bus.m_line); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        rf_beat_t e, o;
        do_start(0, 4, 2, 0, 1'b1);
        watch(25, 1'b0, -1, -1);
        n_cmp++; if (en_cyc_q.size() == 0 || en_cyc_q[0] != 1 || en_addr_q[0] != 0) begin n_mis++;
            $display("FAIL basic_first_read: got cycle %0d addr %0d, want cycle 1 addr 0",
                en_cyc_q.size() ? en_cyc_q[0] : -1, en_addr_q.size() ? en_addr_q[0] : -1); end
        n_cmp++; if (first_valid != 3) begin n_mis++; $display("FAIL basic_latency: got %0d, want 3", first_valid); end
        n_cmp++; if (last_hs_q.size() != 2 || last_hs_q[0] != 6) begin n_mis++;
            $display("FAIL basic_throughput: got %0d last beats, first at %0d, want 2 at 6",
                last_hs_q.size(), last_hs_q.size() ? last_hs_q[0] : -1); end
        n_cmp++; if (en_cyc_q.size() < 5 || en_cyc_q[4] != 7) begin n_mis++;
            $display("FAIL basic_next_line_read: got %0d, want 7", en_cyc_q.size() > 4 ? en_cyc_q[4] : -1); end
        n_cmp++; if (done_q.size() != 1 || last_hs_q.size() != 2 || done_q[0] != last_hs_q[1] + 1 || busy_at_done != 0) begin
            n_mis++; $display("FAIL basic_done: got %0d pulses, busy_at_done %0d, want 1 pulse after final beat, busy 0",
                done_q.size(), busy_at_done); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_mis++; $display("FAIL basic_beat: got none, want data %0d", e.data); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin n_mis++; $display("FAIL basic_beat: got %0d/%0b/%0d, want %0d/%0b/%0d",
                    o.data, o.last, o.line, e.data, e.last, e.line); end end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_mis++; $display("FAIL basic_extra: got %0d extra beats, want 0", obs_q.size()); end
    endtask

    task automatic test_wrap();
        rf_beat_t e, o;
        do_start(24098, 4, 1, 0, 1'b1);
        watch(15, 1'b0, -1, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_mis++; $display("FAIL wrap_beat: got none, want data %0d", e.data); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin n_mis++; $display("FAIL wrap_beat: got %0d/%0b/%0d, want %0d/%0b/%0d",
                    o.data, o.last, o.line, e.data, e.last, e.line); end end
        end
        n_cmp++; if (obs_q.size() != 0 || done_q.size() != 1) begin n_mis++;
            $display("FAIL wrap_end: got %0d extra, %0d done, want 0 extra, 1 done", obs_q.size(), done_q.size()); end
    endtask

    task automatic test_backpressure();
        rf_beat_t e, o;
        do_start(0, 8, 1, 0, 1'b1);
        watch(30, 1'b1, -1, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_mis++; $display("FAIL bp_beat: got none, want data %0d", e.data); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin n_mis++; $display("FAIL bp_beat: got %0d/%0b/%0d, want %0d/%0b/%0d",
                    o.data, o.last, o.line, e.data, e.last, e.line); end end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_mis++; $display("FAIL bp_extra: got %0d extra beats, want 0", obs_q.size()); end
        n_cmp++; if (stall_changes != 0) begin n_mis++; $display("FAIL bp_stable: got %0d changes while stalled, want 0", stall_changes); end
        n_cmp++; if (max_occ > 2) begin n_mis++; $display("FAIL bp_occupancy: got %0d outstanding, want at most 2", max_occ); end
        n_cmp++; if (done_q.size() != 1) begin n_mis++; $display("FAIL bp_done: got %0d pulses, want 1", done_q.size()); end
    endtask

    task automatic test_abort();
        rf_beat_t e, o;
        do_start(0, 8, 1, 0, 1'b0);
        watch(12, 1'b0, 2, -1);
        n_cmp++; if (obs_q.size() != 2 || obs_q[0].data !== 16'd0 || obs_q[1].data !== 16'd1) begin n_mis++;
            $display("FAIL abort_beats: got %0d beats, want 2 beats 0,1", obs_q.size()); end
        n_cmp++; if (abort_cyc != 5) begin n_mis++; $display("FAIL abort_point: got cycle %0d, want 5", abort_cyc); end
        n_cmp++; if (post_abort_valid != 0 || post_abort_busy != 0) begin n_mis++;
            $display("FAIL abort_next: got valid %0d busy %0d, want 0 0", post_abort_valid, post_abort_busy); end
        n_cmp++; if (done_q.size() != 0) begin n_mis++; $display("FAIL abort_done: got %0d pulses, want 0", done_q.size()); end
        do_start(100, 2, 1, 0, 1'b1);
        watch(10, 1'b0, -1, -1);
        n_cmp++; if (first_valid != 3) begin n_mis++; $display("FAIL restart_latency: got %0d, want 3", first_valid); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_mis++; $display("FAIL restart_beat: got none, want data %0d", e.data); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin n_mis++; $display("FAIL restart_beat: got %0d/%0b/%0d, want %0d/%0b/%0d",
                    o.data, o.last, o.line, e.data, e.last, e.line); end end
        end
    endtask

    task automatic test_invalid();
        rf_beat_t e, o;
        do_start(24100, 4, 1, 0, 1'b0);
        watch(4, 1'b0, -1, -1);
        n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL inv_base_err: got %b, want 1", err); end
        @(negedge clk); reset = 1'b1; @(negedge clk); reset = 1'b0;
        n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL inv_reset_clear: got %b, want 0", err); end
        do_start(0, 0, 2, 0, 1'b0);
        watch(8, 1'b0, -1, -1);
        n_cmp++; if (err !== 1'b1) begin n_mis++; $display("FAIL inv_len_err: got %b, want 1", err); end
        n_cmp++; if (busy_cnt != 0 || en_cyc_q.size() != 0) begin n_mis++;
            $display("FAIL inv_idle: got %0d busy cycles, %0d reads, want 0 0", busy_cnt, en_cyc_q.size()); end
        do_start(10, 3, 1, 0, 1'b1);
        watch(12, 1'b0, -1, -1);
        n_cmp++; if (err !== 1'b0) begin n_mis++; $display("FAIL inv_err_clear: got %b, want 0", err); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_mis++; $display("FAIL inv_beat: got none, want data %0d", e.data); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin n_mis++; $display("FAIL inv_beat: got %0d/%0b/%0d, want %0d/%0b/%0d",
                    o.data, o.last, o.line, e.data, e.last, e.line); end end
        end
    endtask

    task automatic test_gap();
        rf_beat_t e, o;
        do_start(0, 2, 2, 3, 1'b1);
        watch(20, 1'b0, -1, 6);
        n_cmp++; if (last_hs_q.size() != 2 || en_cyc_q.size() != 4 || en_cyc_q[2] - last_hs_q[0] != 4) begin n_mis++;
            $display("FAIL gap_distance: got %0d cycles, want 4",
                (last_hs_q.size() > 0 && en_cyc_q.size() > 2) ? en_cyc_q[2] - last_hs_q[0] : -1); end
        n_cmp++; if (err !== 1'b0 || done_q.size() != 1) begin n_mis++;
            $display("FAIL gap_midframe_start: got err %b, %0d done, want 0, 1", err, done_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); n_cmp++;
            if (obs_q.size() == 0) begin n_mis++; $display("FAIL gap_beat: got none, want data %0d", e.data); end
            else begin o = obs_q.pop_front();
                if (o !== e) begin n_mis++; $display("FAIL gap_beat: got %0d/%0b/%0d, want %0d/%0b/%0d",
                    o.data, o.last, o.line, e.data, e.last, e.line); end end
        end
        n_cmp++; if (obs_q.size() != 0) begin n_mis++; $display("FAIL gap_extra: got %0d extra beats, want 0", obs_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_abort();
        test_invalid();
        test_gap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end of test, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
